// File: rtl/hazard_stall_controller.sv
// -----------------------------------------------------------------------------
// hazard_stall_controller
//
// Pipeline sequencing controller for the 5-stage MIPS core (ID/EX region).
//   * Load-use hazard: one-cycle front-end stall with a bubble into ID/EX.
//   * Taken branch resolved in EX: one-cycle flush of IF/ID and ID/EX.
//   * Multi-cycle mult/div: front end frozen while the unit occupies EX.
//
// Parameters
//   MUL_LAT  cycles a mult/div instruction occupies EX (legal 2..255)
//   CNT_W    width of the performance counters
//
// Ports
//   clk              pipeline clock, rising edge
//   rst_n            asynchronous active-low reset
//   IF_ID_rs/rt      source register fields of the instruction in ID
//   ID_EX_rt         destination (rt) of the instruction in EX
//   ID_EX_LeMem      instruction in EX is a load
//   EX_mul_start     instruction in EX is mult/div
//   EX_branch_taken  branch in EX resolved taken
//   PC_Escreve, IF_ID_Escreve, ID_EX_Escreve   write enables (active 1)
//   ID_EX_Bolha, EX_MEM_Bolha                  insert NOP into the register
//   IF_ID_Flush, ID_EX_Flush                   clear the register
//   mul_busy         mult/div sequence in progress (MULBUSY state)
//   mul_done         pulse on the last EX cycle of mult/div
//   stall_cycles     saturating count of cycles with PC_Escreve=0
//   flush_count      saturating count of taken-branch flush cycles
//
// Build option
//   HAZARD_PERF_CNT_EN  when defined, the two performance counters are built;
//                       otherwise stall_cycles and flush_count are tied to 0.
// -----------------------------------------------------------------------------
module hazard_stall_controller #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_rs,
    input  logic [4:0]       IF_ID_rt,
    input  logic [4:0]       ID_EX_rt,
    input  logic             ID_EX_LeMem,
    input  logic             EX_mul_start,
    input  logic             EX_branch_taken,
    output logic             PC_Escreve,
    output logic             IF_ID_Escreve,
    output logic             ID_EX_Escreve,
    output logic             ID_EX_Bolha,
    output logic             EX_MEM_Bolha,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             mul_busy,
    output logic             mul_done,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {
        RUN     = 1'b0,
        MULBUSY = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       load_use;

    // Register 0 is hard-wired to zero, so a load "into" it never creates a
    // real dependency.
    assign load_use = ID_EX_LeMem && (ID_EX_rt != 5'd0) &&
                      ((ID_EX_rt == IF_ID_rs) || (ID_EX_rt == IF_ID_rt));

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output and next-state variable gets a default before the
    // case statement; a path that skipped an assignment would infer a latch.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        PC_Escreve      = 1'b1;
        IF_ID_Escreve   = 1'b1;
        ID_EX_Escreve   = 1'b1;
        ID_EX_Bolha     = 1'b0;
        EX_MEM_Bolha    = 1'b0;
        IF_ID_Flush     = 1'b0;
        ID_EX_Flush     = 1'b0;
        mul_busy        = 1'b0;
        mul_done        = 1'b0;

        unique case (state_q)
            RUN: begin
                // Priority: mult/div start > taken branch > load-use.
                if (EX_mul_start) begin
                    PC_Escreve    = 1'b0;
                    IF_ID_Escreve = 1'b0;
                    ID_EX_Escreve = 1'b0;
                    EX_MEM_Bolha  = 1'b1;
                    cnt_d         = 8'(MUL_LAT - 1);
                    state_d       = MULBUSY;
                end else if (EX_branch_taken) begin
                    // The dependent instruction (if any) is flushed, so a
                    // concurrent load-use match needs no stall.
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                end else if (load_use) begin
                    // The bubble clears ID_EX_LeMem next cycle, so the stall
                    // lasts exactly one cycle.
                    PC_Escreve    = 1'b0;
                    IF_ID_Escreve = 1'b0;
                    ID_EX_Bolha   = 1'b1;
                end
            end

            MULBUSY: begin
                mul_busy = 1'b1;
                if (cnt_q > 8'd1) begin
                    PC_Escreve    = 1'b0;
                    IF_ID_Escreve = 1'b0;
                    ID_EX_Escreve = 1'b0;
                    EX_MEM_Bolha  = 1'b1;
                    cnt_d         = cnt_q - 8'd1;
                end else begin
                    // Last EX cycle: release the pipeline so a back-to-back
                    // mult/div can be seen in RUN on the very next cycle.
                    mul_done = 1'b1;
                    cnt_d    = 8'd0;
                    state_d  = RUN;
                end
            end

            default: begin
                state_d = RUN;
                cnt_d   = 8'd0;
            end
        endcase

        // While reset is held every output is inactive, whatever the inputs.
        if (!rst_n) begin
            PC_Escreve    = 1'b1;
            IF_ID_Escreve = 1'b1;
            ID_EX_Escreve = 1'b1;
            ID_EX_Bolha   = 1'b0;
            EX_MEM_Bolha  = 1'b0;
            IF_ID_Flush   = 1'b0;
            ID_EX_Flush   = 1'b0;
            mul_busy      = 1'b0;
            mul_done      = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // Saturating counters: hold at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!PC_Escreve && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (IF_ID_Flush && (flush_q != {CNT_W{1'b1}})) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_controller
//
// Directed test of hazard_stall_controller with MUL_LAT=4 and CNT_W=4.
// Outputs are compared as a 9-bit vector
//   {PC_Escreve, IF_ID_Escreve, ID_EX_Escreve, ID_EX_Bolha, EX_MEM_Bolha,
//    IF_ID_Flush, ID_EX_Flush, mul_busy, mul_done}
// sampled on the falling edge. Expected counter values come from a small
// saturating model that is advanced from the expected vectors; with
// HAZARD_PERF_CNT_EN undefined the counters are expected to read 0.
// -----------------------------------------------------------------------------
module tb_hazard_stall_controller;

    localparam int unsigned MUL_LAT = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Expected output vectors.
    localparam logic [8:0] V_IDLE  = 9'b111_00_00_00; // all inactive
    localparam logic [8:0] V_LU    = 9'b001_10_00_00; // load-use stall
    localparam logic [8:0] V_FLUSH = 9'b111_00_11_00; // taken-branch flush
    localparam logic [8:0] V_MSTRT = 9'b000_01_00_00; // mult start cycle
    localparam logic [8:0] V_MBUSY = 9'b000_01_00_10; // mult busy, stalled
    localparam logic [8:0] V_MDONE = 9'b111_00_00_11; // mult last cycle

    logic             clk;
    logic             rst_n;
    logic [4:0]       IF_ID_rs;
    logic [4:0]       IF_ID_rt;
    logic [4:0]       ID_EX_rt;
    logic             ID_EX_LeMem;
    logic             EX_mul_start;
    logic             EX_branch_taken;
    logic             PC_Escreve;
    logic             IF_ID_Escreve;
    logic             ID_EX_Escreve;
    logic             ID_EX_Bolha;
    logic             EX_MEM_Bolha;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             mul_busy;
    logic             mul_done;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    int total = 0;
    int bad   = 0;
    int m_stall = 0;
    int m_flush = 0;

    hazard_stall_controller #(
        .MUL_LAT (MUL_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .IF_ID_rs        (IF_ID_rs),
        .IF_ID_rt        (IF_ID_rt),
        .ID_EX_rt        (ID_EX_rt),
        .ID_EX_LeMem     (ID_EX_LeMem),
        .EX_mul_start    (EX_mul_start),
        .EX_branch_taken (EX_branch_taken),
        .PC_Escreve      (PC_Escreve),
        .IF_ID_Escreve   (IF_ID_Escreve),
        .ID_EX_Escreve   (ID_EX_Escreve),
        .ID_EX_Bolha     (ID_EX_Bolha),
        .EX_MEM_Bolha    (EX_MEM_Bolha),
        .IF_ID_Flush     (IF_ID_Flush),
        .ID_EX_Flush     (ID_EX_Flush),
        .mul_busy        (mul_busy),
        .mul_done        (mul_done),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {PC_Escreve, IF_ID_Escreve, ID_EX_Escreve, ID_EX_Bolha,
                EX_MEM_Bolha, IF_ID_Flush, ID_EX_Flush, mul_busy, mul_done};
    endfunction

    task automatic drive(input logic lemem, input logic [4:0] ex_rt,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic mul, input logic br);
        ID_EX_LeMem     = lemem;
        ID_EX_rt        = ex_rt;
        IF_ID_rs        = rs;
        IF_ID_rt        = rt;
        EX_mul_start    = mul;
        EX_branch_taken = br;
    endtask

    // One clock cycle: check outputs at the falling edge, advance the counter
    // model from the expected vector, then step past the rising edge.
    task automatic cycle(input string tag, input logic [8:0] exp);
        @(negedge clk);
        check(tag, 32'(outs()), 32'(exp));
        if (!exp[8] && m_stall < CNT_MAX) m_stall++;
        if (exp[3]  && m_flush < CNT_MAX) m_flush++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_stall"}, 32'(stall_cycles), PERF ? 32'(m_stall) : 32'd0);
        check({tag, "_flush"}, 32'(flush_count),  PERF ? 32'(m_flush) : 32'd0);
    endtask

    initial begin
        // Reset with hazard-triggering inputs: outputs must stay inactive.
        rst_n = 1'b0;
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1);
        #3;
        check("reset_outs", 32'(outs()), 32'(V_IDLE));
        check_counters("reset");
        @(posedge clk);
        #1;
        check("reset_outs_edge", 32'(outs()), 32'(V_IDLE));
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cycle("idle", V_IDLE);

        // Load-use on rs, then the bubble removes the load: one cycle only.
        drive(1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0);
        cycle("lu_rs", V_LU);
        drive(1'b0, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0);
        cycle("lu_rs_after", V_IDLE);

        // Load-use on rt.
        drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0);
        cycle("lu_rt", V_LU);

        // Register 0 never stalls; no load or no match never stalls.
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        cycle("lu_r0", V_IDLE);
        drive(1'b1, 5'd6, 5'd3, 5'd4, 1'b0, 1'b0);
        cycle("lu_nomatch", V_IDLE);
        drive(1'b0, 5'd6, 5'd6, 5'd6, 1'b0, 1'b0);
        cycle("lu_noload", V_IDLE);
        check_counters("after_lu");

        // Taken branch with simultaneous load-use match: flush wins.
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
        cycle("branch_lu", V_FLUSH);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        cycle("branch_after", V_IDLE);
        check_counters("after_branch");

        // Mult with branch and load-use also asserted: mult has priority,
        // and MULBUSY ignores the other inputs. Held high: back-to-back.
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1);
        cycle("mul1_start", V_MSTRT);
        cycle("mul1_busy3", V_MBUSY);
        cycle("mul1_busy2", V_MBUSY);
        cycle("mul1_done",  V_MDONE);
        check_counters("after_mul1");
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        cycle("mul2_start", V_MSTRT);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        cycle("mul2_busy3", V_MBUSY);
        cycle("mul2_busy2", V_MBUSY);
        cycle("mul2_done",  V_MDONE);
        cycle("mul2_after", V_IDLE);
        check_counters("after_mul2");

        // Reset in MULBUSY with cnt=2: abort, no mul_done, back in RUN.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        cycle("mul3_start", V_MSTRT);
        drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
        cycle("mul3_busy3", V_MBUSY);
        rst_n = 1'b0;
        #1;
        check("midrst_outs", 32'(outs()), 32'(V_IDLE));
        m_stall = 0;
        m_flush = 0;
        check_counters("midrst");
        @(negedge clk);
        check("midrst_outs_neg", 32'(outs()), 32'(V_IDLE));
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cycle("post_rst_run", V_IDLE);
        cycle("post_rst_run2", V_IDLE);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        cycle("post_rst_mul", V_MSTRT);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        cycle("post_rst_busy3", V_MBUSY);
        cycle("post_rst_busy2", V_MBUSY);
        cycle("post_rst_done", V_MDONE);
        check_counters("post_rst");

        // Sustained load-use stall drives stall_cycles into saturation.
        drive(1'b1, 5'd12, 5'd12, 5'd12, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cycle("sat_lu", V_LU);
        end
        check_counters("sat");
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        cycle("sat_after", V_IDLE);
        check_counters("sat_hold");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Pipeline sequencing controller for the 5-stage MIPS core, sitting beside the forwarding unit in the ID/EX region. It detects load-use hazards and inserts one bubble. It flushes IF/ID and ID/EX on a taken branch resolved in EX. It freezes the front of the pipeline while the multi-cycle multiply/divide unit occupies EX. Optional performance counters record stall and flush activity.

## Interface
Parameters:
- MUL_LAT, 4, cycles a mult/div instruction occupies EX; legal range 2..255
- CNT_W, 16, width of the performance counters

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- IF_ID_rs  input  5  rs field of the instruction in ID
- IF_ID_rt  input  5  rt field of the instruction in ID
- ID_EX_rt  input  5  destination (rt) of the instruction in EX
- ID_EX_LeMem  input  1  instruction in EX is a load
- EX_mul_start  input  1  instruction in EX is mult/div
- EX_branch_taken  input  1  branch in EX resolved taken
- PC_Escreve  output  1  PC write enable
- IF_ID_Escreve  output  1  IF/ID register write enable
- ID_EX_Escreve  output  1  ID/EX register write enable
- ID_EX_Bolha  output  1  load a NOP into ID/EX
- EX_MEM_Bolha  output  1  load a NOP into EX/MEM
- IF_ID_Flush  output  1  clear IF/ID
- ID_EX_Flush  output  1  clear ID/EX
- mul_busy  output  1  multi-cycle operation in progress
- mul_done  output  1  single-cycle pulse on the last EX cycle of mult/div
- stall_cycles  output  CNT_W  count of cycles with PC_Escreve=0
- flush_count  output  CNT_W  count of taken-branch flushes

## Operation
- State register values: RUN, MULBUSY. Down-counter `cnt` is 8 bits wide.
- Outputs are a combinational decode of the state and the current inputs. Inactive values: Escreve signals = 1, all others = 0.
- Input priority in RUN: EX_mul_start > EX_branch_taken > load-use. The three EX-side conditions are mutually exclusive by construction. If more than one is asserted, only the highest-priority condition acts.
- RUN, EX_mul_start=1:
  - Assert PC_Escreve=0, IF_ID_Escreve=0, ID_EX_Escreve=0, EX_MEM_Bolha=1.
  - Load cnt=MUL_LAT-1 and go to MULBUSY.
- MULBUSY, cnt>1:
  - Drive the same stall outputs as the start cycle, with mul_busy=1.
  - Decrement cnt.
  - Ignore EX_mul_start, EX_branch_taken and load-use.
- MULBUSY, cnt==1:
  - Deassert the stall so the pipeline advances. Assert mul_busy=1 and mul_done=1.
  - Go to RUN.
  - Net effect: the mult/div instruction occupies EX for exactly MUL_LAT cycles, and the front end stalls for MUL_LAT-1 cycles.
- RUN, EX_branch_taken=1:
  - Assert IF_ID_Flush=1 and ID_EX_Flush=1 for that cycle only.
  - A simultaneous load-use match is suppressed, because the dependent instruction is being flushed.
- RUN, load-use: the condition is ID_EX_LeMem=1 AND ID_EX_rt!=0 AND (ID_EX_rt==IF_ID_rs OR ID_EX_rt==IF_ID_rt).
  - Assert PC_Escreve=0, IF_ID_Escreve=0, ID_EX_Bolha=1 for one cycle.
  - Stay in RUN. The bubble clears ID_EX_LeMem on the next cycle, so the stall cannot repeat.
- Register 0 never triggers a load-use stall.

## Timing
- Reset (rst_n low, asynchronous):
  - State=RUN, cnt=0, counters=0.
  - All outputs are forced inactive regardless of inputs: PC_Escreve=1, IF_ID_Escreve=1, ID_EX_Escreve=1, all others 0.
- Reset asserted during MULBUSY aborts the operation immediately. No mul_done is produced.
- Release is synchronous to the next rising edge; the first active cycle is in RUN.
- Load-use stall: exactly 1 cycle.
- Flush: 1 cycle, same cycle as EX_branch_taken.
- Mult/div: stall outputs active in the start cycle plus MUL_LAT-2 MULBUSY cycles. mul_done occurs on cycle MUL_LAT-1 after the start cycle.
- EX_mul_start seen in RUN on the cycle after mul_done is a new instruction and starts a new sequence. Back-to-back mult/div is supported with no idle cycle.
- Counters saturate at 2^CNT_W-1 and never wrap.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles increments on every cycle with PC_Escreve=0.
  - flush_count increments on every flush cycle.
  - Both counters are saturating.
- HAZARD_PERF_CNT_EN undefined: no counter registers are built, and stall_cycles and flush_count are tied to 0.

## Test plan
- Reset mid-run: assert rst_n=0 while in MULBUSY with cnt=2 → PC_Escreve=1, mul_busy=0, no mul_done; after release, state is RUN.
- Load-use: ID_EX_LeMem=1, ID_EX_rt=5, IF_ID_rs=5 → one cycle of PC_Escreve=0, IF_ID_Escreve=0, ID_EX_Bolha=1. With ID_EX_rt=0 → no stall.
- Branch plus load-use in the same cycle: EX_branch_taken=1 with a load-use match → IF_ID_Flush=ID_EX_Flush=1, PC_Escreve=1, ID_EX_Bolha=0; flush_count +1.
- Mult, MUL_LAT=4: EX_mul_start=1 held high → stall active for 3 cycles, mul_done=1 on the 4th cycle, stall_cycles=3.
- Back-to-back mult: two consecutive mult instructions with MUL_LAT=4 → second sequence starts on the cycle after mul_done; stall_cycles=6 in total.
- Counter saturation with CNT_W=4 and a sustained stall → stall_cycles holds at 15. With the macro undefined → stall_cycles stays 0.
